// File: rtl/pift_pkg.sv
// Shared types and helper rules for the PIFT taint shadow memories.
// Holds the scrub state encoding, the per-bit write-merge rule and the address range check.
package pift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } scrub_state_t;

  // A tainted enable may or may not have fired, so the bit is conservatively tainted.
  function automatic logic merge_bit(input logic old, input logic en, input logic en_taint,
                                     input logic data_taint, input logic addr_taint);
    if (en) return data_taint | addr_taint | en_taint;
    if (en_taint) return 1'b1;
    return old;
  endfunction

  function automatic logic in_range(input logic [31:0] addr, input int offset, input int size);
    longint a;
    a = longint'(addr);
    return (a >= longint'(offset)) && (a < longint'(offset) + longint'(size));
  endfunction

endpackage

// File: rtl/taintcell_mem_sync_if.sv
// Port bundle of the synchronous taint shadow memory: read/write port taints,
// scrub control and status.
interface taintcell_mem_sync_if #(
  parameter int ABITS    = 4,
  parameter int WIDTH    = 8,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2
);
  logic [RD_PORTS-1:0]       RD_EN;
  logic [RD_PORTS-1:0]       RD_EN_taint;
  logic [RD_PORTS-1:0]       RD_SRST;
  logic [RD_PORTS-1:0]       RD_SRST_taint;
  logic [RD_PORTS*ABITS-1:0] RD_ADDR;
  logic [RD_PORTS*ABITS-1:0] RD_ADDR_taint;
  logic [RD_PORTS*WIDTH-1:0] RD_DATA_taint;
  logic [WR_PORTS*WIDTH-1:0] WR_EN;
  logic [WR_PORTS*WIDTH-1:0] WR_EN_taint;
  logic [WR_PORTS*ABITS-1:0] WR_ADDR;
  logic [WR_PORTS*ABITS-1:0] WR_ADDR_taint;
  logic [WR_PORTS*WIDTH-1:0] WR_DATA_taint;
  logic                      SCRUB_REQ;
  logic                      SCRUB_BUSY;
  logic                      OOR_SEEN;
  logic [ABITS:0]            taint_sum;

  modport master (
    output RD_EN, RD_EN_taint, RD_SRST, RD_SRST_taint, RD_ADDR, RD_ADDR_taint,
    output WR_EN, WR_EN_taint, WR_ADDR, WR_ADDR_taint, WR_DATA_taint, SCRUB_REQ,
    input  RD_DATA_taint, SCRUB_BUSY, OOR_SEEN, taint_sum
  );

  modport slave (
    input  RD_EN, RD_EN_taint, RD_SRST, RD_SRST_taint, RD_ADDR, RD_ADDR_taint,
    input  WR_EN, WR_EN_taint, WR_ADDR, WR_ADDR_taint, WR_DATA_taint, SCRUB_REQ,
    output RD_DATA_taint, SCRUB_BUSY, OOR_SEEN, taint_sum
  );
endinterface

// File: rtl/taintcell_mem_rdport.sv
// One read port of the taint shadow memory: transparency lane merge, read
// priority (srst > tainted enable > enable > hold) and the output register.
module taintcell_mem_rdport #(
  parameter int WIDTH    = 8,
  parameter int WR_PORTS = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      en_taint,
  input  logic                      srst,
  input  logic                      srst_taint,
  input  logic                      addr_taint,
  input  logic                      oor,
  input  logic [WIDTH-1:0]          entry,
  input  logic [WR_PORTS-1:0]       hit,
  input  logic [WR_PORTS*WIDTH-1:0] wr_en,
  input  logic [WR_PORTS*WIDTH-1:0] wr_new,
  output logic [WIDTH-1:0]          rd_taint
);

  logic [WIDTH-1:0] rd_val_p0;
  logic [WIDTH-1:0] rd_taint_p1;

  // Later write ports overwrite earlier ones, matching the array's collision rule.
  always_comb begin
    rd_val_p0 = entry;
    for (int w = 0; w < WR_PORTS; w++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (hit[w] && wr_en[w*WIDTH+j]) rd_val_p0[j] = wr_new[w*WIDTH+j];
      end
    end
    if (oor) rd_val_p0 = '1;
    rd_val_p0 = rd_val_p0 | {WIDTH{addr_taint}};
  end

  // p0 -> p1: registered read taint
  always_ff @(posedge CLK) begin
    if (reset)           rd_taint_p1 <= '0;
    else if (srst)       rd_taint_p1 <= {WIDTH{srst_taint}};
    else if (en_taint)   rd_taint_p1 <= '1;
    else if (en)         rd_taint_p1 <= rd_val_p0;
  end

  assign rd_taint = rd_taint_p1;

endmodule

// File: rtl/taintcell_mem_sync.sv
// Synchronous per-bit taint shadow memory with multi-port access, an
// incrementally maintained tainted-entry count and an in-place scrub sequencer.
module taintcell_mem_sync
  import pift_pkg::*;
#(
  parameter             MEMID                = "",
  parameter int         SIZE                 = 16,
  parameter int         OFFSET               = 0,
  parameter int         ABITS                = 4,
  parameter int         WIDTH                = 8,
  parameter int         RD_PORTS             = 2,
  parameter int         WR_PORTS             = 2,
  parameter logic [63:0] RD_TRANSPARENCY_MASK = 64'd0
) (
  input  logic                 CLK,
  input  logic                 reset,
  taintcell_mem_sync_if.slave  bus
);

  if (ABITS < 1 || ABITS > 30 || SIZE < 1 || SIZE > (1 << ABITS)) begin : g_bad_size
    $error("taintcell_mem_sync %s: SIZE %0d does not fit ABITS %0d", MEMID, SIZE, ABITS);
  end
  if (RD_PORTS * WR_PORTS > 64 ||
      (RD_PORTS * WR_PORTS < 64 &&
       (RD_TRANSPARENCY_MASK >> (RD_PORTS * WR_PORTS)) != 64'd0)) begin : g_bad_mask
    $error("taintcell_mem_sync %s: RD_TRANSPARENCY_MASK wider than RD_PORTS*WR_PORTS", MEMID);
  end

  logic [WIDTH-1:0]          mem_q [SIZE];
  logic [WIDTH-1:0]          mem_d [SIZE];
  logic [WR_PORTS-1:0]       wr_ok, wr_act, wr_at;
  logic [ABITS-1:0]          wr_idx [WR_PORTS];
  logic [WR_PORTS*WIDTH-1:0] wr_new;
  logic [RD_PORTS-1:0]       rd_ok, rd_act, rd_at;
  logic [ABITS-1:0]          rd_idx [RD_PORTS];
  logic [RD_PORTS*WIDTH-1:0] rd_flat;
  scrub_state_t              state_q, state_d;
  logic [ABITS-1:0]          ptr_q, ptr_d;
  logic [ABITS:0]            taint_sum_q, taint_sum_d, rises, falls;
  logic                      oor_q, oor_hit;

  // Address decode uses a wide compare so addresses below OFFSET never wrap into range.
  always_comb begin
    for (int w = 0; w < WR_PORTS; w++) begin
      wr_ok[w]  = in_range(32'(bus.WR_ADDR[w*ABITS +: ABITS]), OFFSET, SIZE);
      wr_idx[w] = bus.WR_ADDR[w*ABITS +: ABITS] - ABITS'(OFFSET);
      wr_at[w]  = |bus.WR_ADDR_taint[w*ABITS +: ABITS];
      wr_act[w] = (|bus.WR_EN[w*WIDTH +: WIDTH]) | (|bus.WR_EN_taint[w*WIDTH +: WIDTH]);
      for (int j = 0; j < WIDTH; j++) begin
        wr_new[w*WIDTH+j] = merge_bit(1'b0, 1'b1, bus.WR_EN_taint[w*WIDTH+j],
                                      bus.WR_DATA_taint[w*WIDTH+j], wr_at[w]);
      end
    end
    for (int r = 0; r < RD_PORTS; r++) begin
      rd_ok[r]  = in_range(32'(bus.RD_ADDR[r*ABITS +: ABITS]), OFFSET, SIZE);
      rd_idx[r] = bus.RD_ADDR[r*ABITS +: ABITS] - ABITS'(OFFSET);
      rd_at[r]  = |bus.RD_ADDR_taint[r*ABITS +: ABITS];
      rd_act[r] = bus.RD_EN[r] | bus.RD_EN_taint[r];
    end
    oor_hit = (|(rd_act & ~rd_ok)) | (|(wr_act & ~wr_ok));
  end

  // Scrub clear is applied first so a same-cycle write to the scrub pointer wins.
  always_comb begin
    for (int e = 0; e < SIZE; e++) begin
      mem_d[e] = mem_q[e];
      if (state_q == SCRUB && ptr_q == ABITS'(e)) mem_d[e] = '0;
      for (int w = 0; w < WR_PORTS; w++) begin
        if (wr_ok[w] && wr_idx[w] == ABITS'(e)) begin
          for (int j = 0; j < WIDTH; j++) begin
            mem_d[e][j] = merge_bit(mem_d[e][j], bus.WR_EN[w*WIDTH+j],
                                    bus.WR_EN_taint[w*WIDTH+j],
                                    bus.WR_DATA_taint[w*WIDTH+j], wr_at[w]);
          end
        end
      end
    end
  end

  always_comb begin
    rises = '0;
    falls = '0;
    for (int e = 0; e < SIZE; e++) begin
      if (mem_q[e] == '0 && mem_d[e] != '0) rises = rises + 1'b1;
      if (mem_q[e] != '0 && mem_d[e] == '0) falls = falls + 1'b1;
    end
    taint_sum_d = taint_sum_q + rises - falls;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.SCRUB_REQ) begin
          state_d = SCRUB;
          ptr_d   = '0;
        end
      end
      SCRUB: begin
        if (ptr_q == ABITS'(SIZE - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int e = 0; e < SIZE; e++) mem_q[e] <= '0;
      taint_sum_q <= '0;
      oor_q       <= 1'b0;
    end else begin
      for (int e = 0; e < SIZE; e++) mem_q[e] <= mem_d[e];
      taint_sum_q <= taint_sum_d;
      oor_q       <= oor_q | oor_hit;
    end
  end

  for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
    logic [WIDTH-1:0]    entry;
    logic [WR_PORTS-1:0] hit;

    always_comb begin
      entry = rd_ok[r] ? mem_q[rd_idx[r]] : '0;
      for (int w = 0; w < WR_PORTS; w++) begin
        hit[w] = RD_TRANSPARENCY_MASK[r*WR_PORTS+w] && wr_ok[w] && rd_ok[r] &&
                 (wr_idx[w] == rd_idx[r]);
      end
    end

    taintcell_mem_rdport #(
      .WIDTH    (WIDTH),
      .WR_PORTS (WR_PORTS)
    ) u_rdport (
      .CLK        (CLK),
      .reset      (reset),
      .en         (bus.RD_EN[r]),
      .en_taint   (bus.RD_EN_taint[r]),
      .srst       (bus.RD_SRST[r]),
      .srst_taint (bus.RD_SRST_taint[r]),
      .addr_taint (rd_at[r]),
      .oor        (~rd_ok[r]),
      .entry      (entry),
      .hit        (hit),
      .wr_en      (bus.WR_EN),
      .wr_new     (wr_new),
      .rd_taint   (rd_flat[r*WIDTH +: WIDTH])
    );
  end

  assign bus.RD_DATA_taint = rd_flat;
  assign bus.SCRUB_BUSY    = (state_q == SCRUB);
  assign bus.OOR_SEEN      = oor_q;
  assign bus.taint_sum     = taint_sum_q;

endmodule

// File: tb/tb_taintcell_mem_sync.sv
// Bench for taintcell_mem_sync: a table of write/read vectors plus hand sequences
// for read priority, collisions, transparency, scrub, out-of-range and reset.
module tb_taintcell_mem_sync;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  taintcell_mem_sync_if #(.ABITS(4), .WIDTH(8), .RD_PORTS(2), .WR_PORTS(2)) bus ();
  taintcell_mem_sync_if #(.ABITS(4), .WIDTH(8), .RD_PORTS(2), .WR_PORTS(2)) bus_o ();

  // Read port 1 is transparent to both write ports; read port 0 is not.
  taintcell_mem_sync #(
    .MEMID("main"), .SIZE(16), .OFFSET(0), .ABITS(4), .WIDTH(8),
    .RD_PORTS(2), .WR_PORTS(2), .RD_TRANSPARENCY_MASK(64'hC)
  ) dut (.CLK(CLK), .reset(reset), .bus(bus));

  taintcell_mem_sync #(
    .MEMID("offs"), .SIZE(12), .OFFSET(4), .ABITS(4), .WIDTH(8),
    .RD_PORTS(2), .WR_PORTS(2), .RD_TRANSPARENCY_MASK(64'h0)
  ) dut_o (.CLK(CLK), .reset(reset), .bus(bus_o));

  typedef struct {
    int          d;
    int          port;
    logic [7:0]  exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [3:0] waddr;
    logic [7:0] wen;
    logic [7:0] wen_t;
    logic [7:0] wdata_t;
    logic [3:0] waddr_t;
    logic [3:0] raddr;
    logic [3:0] raddr_t;
    logic [7:0] exp_rd;
    logic [4:0] exp_sum;
  } tv_t;
  tv_t tv[9];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    sb_t e;
    logic [7:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = (e.d == 0) ? bus.RD_DATA_taint[e.port*8 +: 8] : bus_o.RD_DATA_taint[e.port*8 +: 8];
      check(e.name, {24'd0, act}, {24'd0, e.exp});
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    sb_check();
  endtask

  task automatic idle();
    bus.RD_EN = '0;   bus.RD_EN_taint = '0;   bus.RD_SRST = '0;   bus.RD_SRST_taint = '0;
    bus.RD_ADDR = '0; bus.RD_ADDR_taint = '0; bus.WR_EN = '0;     bus.WR_EN_taint = '0;
    bus.WR_ADDR = '0; bus.WR_ADDR_taint = '0; bus.WR_DATA_taint = '0; bus.SCRUB_REQ = 1'b0;
    bus_o.RD_EN = '0;   bus_o.RD_EN_taint = '0;   bus_o.RD_SRST = '0;   bus_o.RD_SRST_taint = '0;
    bus_o.RD_ADDR = '0; bus_o.RD_ADDR_taint = '0; bus_o.WR_EN = '0;     bus_o.WR_EN_taint = '0;
    bus_o.WR_ADDR = '0; bus_o.WR_ADDR_taint = '0; bus_o.WR_DATA_taint = '0; bus_o.SCRUB_REQ = 1'b0;
  endtask

  task automatic wr(input int d, input int p, input logic [3:0] addr, input logic [7:0] en,
                    input logic [7:0] data_t, input logic [3:0] addr_t, input logic [7:0] en_t);
    if (d == 0) begin
      bus.WR_ADDR[p*4 +: 4] = addr;  bus.WR_ADDR_taint[p*4 +: 4] = addr_t;
      bus.WR_EN[p*8 +: 8]   = en;    bus.WR_EN_taint[p*8 +: 8]   = en_t;
      bus.WR_DATA_taint[p*8 +: 8] = data_t;
    end else begin
      bus_o.WR_ADDR[p*4 +: 4] = addr;  bus_o.WR_ADDR_taint[p*4 +: 4] = addr_t;
      bus_o.WR_EN[p*8 +: 8]   = en;    bus_o.WR_EN_taint[p*8 +: 8]   = en_t;
      bus_o.WR_DATA_taint[p*8 +: 8] = data_t;
    end
  endtask

  task automatic rd(input int d, input int p, input logic [3:0] addr, input logic en,
                    input logic en_t, input logic srst, input logic srst_t,
                    input logic [3:0] addr_t, input logic [7:0] exp, input string name);
    sb_t e;
    if (d == 0) begin
      bus.RD_ADDR[p*4 +: 4] = addr; bus.RD_ADDR_taint[p*4 +: 4] = addr_t;
      bus.RD_EN[p] = en; bus.RD_EN_taint[p] = en_t; bus.RD_SRST[p] = srst; bus.RD_SRST_taint[p] = srst_t;
    end else begin
      bus_o.RD_ADDR[p*4 +: 4] = addr; bus_o.RD_ADDR_taint[p*4 +: 4] = addr_t;
      bus_o.RD_EN[p] = en; bus_o.RD_EN_taint[p] = en_t; bus_o.RD_SRST[p] = srst; bus_o.RD_SRST_taint[p] = srst_t;
    end
    e.d = d; e.port = p; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    int n;
    //        waddr  wen    wen_t  wdata  waddr_t raddr raddr_t exp_rd sum
    tv[0] = '{4'd3,  8'hFF, 8'h00, 8'h0F, 4'h0,  4'd3, 4'h0, 8'h0F, 5'd1};
    tv[1] = '{4'd5,  8'hFF, 8'h00, 8'h00, 4'h1,  4'd5, 4'h0, 8'hFF, 5'd2};
    tv[2] = '{4'd6,  8'h00, 8'h01, 8'h00, 4'h0,  4'd6, 4'h0, 8'h01, 5'd3};
    tv[3] = '{4'd3,  8'hF0, 8'h00, 8'h00, 4'h0,  4'd3, 4'h0, 8'h0F, 5'd3};
    tv[4] = '{4'd3,  8'h0F, 8'h00, 8'h00, 4'h0,  4'd3, 4'h0, 8'h00, 5'd2};
    tv[5] = '{4'd6,  8'h01, 8'h00, 8'h00, 4'h0,  4'd6, 4'h0, 8'h00, 5'd1};
    tv[6] = '{4'd9,  8'h3C, 8'h00, 8'hFF, 4'h0,  4'd9, 4'h0, 8'h3C, 5'd2};
    tv[7] = '{4'd9,  8'hC3, 8'h80, 8'h00, 4'h0,  4'd9, 4'h0, 8'hBC, 5'd2};
    tv[8] = '{4'd10, 8'h00, 8'h00, 8'hFF, 4'h0,  4'd9, 4'h4, 8'hFF, 5'd2};

    idle();
    reset = 1'b1;
    step();
    step();
    check("rst_rd_data", {16'd0, bus.RD_DATA_taint}, 32'd0);
    check("rst_sum", {27'd0, bus.taint_sum}, 32'd0);
    check("rst_busy", {31'd0, bus.SCRUB_BUSY}, 32'd0);
    check("rst_oor", {31'd0, bus.OOR_SEEN}, 32'd0);
    check("rst_oor_o", {31'd0, bus_o.OOR_SEEN}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      idle();
      wr(0, 0, tv[i].waddr, tv[i].wen, tv[i].wdata_t, tv[i].waddr_t, tv[i].wen_t);
      step();
      idle();
      rd(0, 0, tv[i].raddr, 1'b1, 1'b0, 1'b0, 1'b0, tv[i].raddr_t, tv[i].exp_rd,
         $sformatf("vec%0d_rd", i));
      step();
      check($sformatf("vec%0d_sum", i), {27'd0, bus.taint_sum}, {27'd0, tv[i].exp_sum});
    end

    // Read priority: srst with and without taint, tainted enable, hold.
    idle(); rd(0, 0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, "srst_clean"); step();
    idle(); rd(0, 0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 8'hFF, "srst_taint"); step();
    idle(); rd(0, 0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, "rd_clean3");  step();
    idle(); rd(0, 0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'hFF, "en_taint");   step();
    idle(); rd(0, 0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'hFF, "rd_hold");    step();

    // Collision on idx 2: port 1 wins; transparent port sees it immediately.
    idle();
    wr(0, 0, 4'd2, 8'hFF, 8'hAA, 4'h0, 8'h00);
    wr(0, 1, 4'd2, 8'hFF, 8'h55, 4'h0, 8'h00);
    rd(0, 1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h55, "transp_collide");
    rd(0, 0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, "nontransp_old");
    step();
    idle(); rd(0, 0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h55, "collide_stored"); step();
    check("collide_sum", {27'd0, bus.taint_sum}, 32'd3);

    // Lane merge: only enabled lanes bypass, the rest come from storage.
    idle();
    wr(0, 0, 4'd5, 8'h0F, 8'h00, 4'h0, 8'h00);
    rd(0, 1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'hF0, "transp_lanes");
    step();
    idle(); rd(0, 0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'hF0, "lanes_stored"); step();

    // Scrub: four tainted entries, one write survives at the scrub pointer.
    idle(); wr(0, 0, 4'd12, 8'hFF, 8'h01, 4'h0, 8'h00); step();
    check("pre_scrub_sum", {27'd0, bus.taint_sum}, 32'd4);
    idle(); bus.SCRUB_REQ = 1'b1; step();
    check("busy_rise", {31'd0, bus.SCRUB_BUSY}, 32'd1);
    n = 1;
    for (int c = 0; c < 40 && bus.SCRUB_BUSY; c++) begin
      idle();
      if (n == 2) rd(0, 0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'hBC, "unscrubbed_rd");
      if (n == 3) bus.SCRUB_REQ = 1'b1;
      if (n == 8) wr(0, 0, 4'd7, 8'hFF, 8'h5A, 4'h0, 8'h00);
      step();
      if (bus.SCRUB_BUSY) n++;
    end
    check("busy_len", n, 32'd16);
    check("scrub_sum", {27'd0, bus.taint_sum}, 32'd1);
    idle();
    rd(0, 0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h5A, "scrub_survivor");
    rd(0, 1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, "scrub_cleared");
    step();
    check("main_oor_clear", {31'd0, bus.OOR_SEEN}, 32'd0);

    // Out of range on the OFFSET=4 instance.
    idle(); rd(1, 0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'hFF, "oor_rd"); step();
    check("oor_flag", {31'd0, bus_o.OOR_SEEN}, 32'd1);
    idle(); wr(1, 0, 4'd2, 8'hFF, 8'hFF, 4'h0, 8'h00); step();
    check("oor_wr_sum", {27'd0, bus_o.taint_sum}, 32'd0);
    idle(); rd(1, 0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, "oor_first"); step();
    idle(); wr(1, 1, 4'd15, 8'hFF, 8'h03, 4'h0, 8'h00); step();
    idle(); rd(1, 1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h03, "oor_last"); step();
    check("oor_last_sum", {27'd0, bus_o.taint_sum}, 32'd1);

    // Reset in the middle of a scrub.
    idle(); bus.SCRUB_REQ = 1'b1; step();
    idle(); step(); step(); step();
    check("mid_busy", {31'd0, bus.SCRUB_BUSY}, 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check("rs_busy", {31'd0, bus.SCRUB_BUSY}, 32'd0);
    check("rs_sum", {27'd0, bus.taint_sum}, 32'd0);
    check("rs_oor_o", {31'd0, bus_o.OOR_SEEN}, 32'd0);
    check("rs_sum_o", {27'd0, bus_o.taint_sum}, 32'd0);
    check("rs_rd_o", {16'd0, bus_o.RD_DATA_taint}, 32'd0);
    idle();
    rd(0, 0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, "rs_rd7_p0");
    rd(0, 1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, "rs_rd7_p1");
    rd(1, 0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, "rs_rd15_o");
    step();
    check("rs_busy_stays", {31'd0, bus.SCRUB_BUSY}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
